// File: rtl/dac_bus_rx.sv
// dac_bus_rx: far-end receiver for the interleaved fast-DAC bus.
// Registers the bus once, and pairs the words into B/A channel pairs.
// Each word is converted from offset-binary, negative-slope code to two's complement.
// A HUNT/SYNC/LOCKED state machine tracks framing. Framing errors seen while
// locked are counted.
module dac_bus_rx #(
   parameter int unsigned LOCK_PAIRS = 4
) (
   input  logic        dac_clk_2x,
   input  logic        dac_rst,
   input  logic [13:0] dac_dat_i,
   input  logic        dac_sel_i,
   input  logic        dac_vld_i,
   output logic [13:0] dat_a_o,
   output logic [13:0] dat_b_o,
   output logic        valid_o,
   output logic        locked_o,
   output logic [15:0] err_cnt_o,
   output logic [31:0] pair_cnt_o
);

   localparam int unsigned DW  = 14;
   localparam int unsigned GW  = 4;
   localparam int unsigned ECW = 16;
   localparam int unsigned PCW = 32;

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_SYNC   = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   // stage-1 input registers
   logic [DW-1:0]  s1_dat_q;
   logic           s1_sel_q;
   logic           s1_vld_q;

   // framing state
   logic [1:0]     state_q, state_d;
   logic           expect_a_q, expect_a_d;
   logic [GW-1:0]  good_q, good_d;
   logic [DW-1:0]  hold_b_q, hold_b_d;

   // output registers
   logic [DW-1:0]  dat_a_q, dat_a_d;
   logic [DW-1:0]  dat_b_q, dat_b_d;
   logic           valid_q, valid_d;
   logic           locked_q, locked_d;
   logic [ECW-1:0] err_cnt_q, err_cnt_d;
   logic [PCW-1:0] pair_cnt_q, pair_cnt_d;

   logic [DW-1:0]  word_conv_c;
   logic           word_ok_c;
   logic [GW-1:0]  good_inc_c;

   // Sample the bus pins once before any decoding
   always_ff @(posedge dac_clk_2x) begin
      if (dac_rst) begin
         s1_dat_q <= '0;
         s1_sel_q <= 1'b0;
         s1_vld_q <= 1'b0;
      end else begin
         s1_dat_q <= dac_dat_i;
         s1_sel_q <= dac_sel_i;
         s1_vld_q <= dac_vld_i;
      end
   end

   // Offset-binary negative-slope code to two's complement
   always_comb begin
      word_conv_c = {s1_dat_q[DW-1], ~s1_dat_q[DW-2:0]};
   end

   // The word is well-formed when its select matches the expected channel (1 = B)
   always_comb begin
      word_ok_c  = (s1_sel_q != expect_a_q);
      good_inc_c = good_q + GW'(1);
   end

   // Next-state and output logic; only valid stage-1 words move anything
   always_comb begin
      state_d    = state_q;
      expect_a_d = expect_a_q;
      good_d     = good_q;
      hold_b_d   = hold_b_q;
      dat_a_d    = dat_a_q;
      dat_b_d    = dat_b_q;
      valid_d    = 1'b0;
      err_cnt_d  = err_cnt_q;
      pair_cnt_d = pair_cnt_q;

      if (s1_vld_q) begin
         case (state_q)
            ST_HUNT: begin
               // A words are dropped; a B word opens a candidate pair
               if (s1_sel_q) begin
                  hold_b_d   = word_conv_c;
                  expect_a_d = 1'b1;
                  good_d     = '0;
                  state_d    = ST_SYNC;
               end
            end

            ST_SYNC: begin
               if (!word_ok_c) begin
                  state_d    = ST_HUNT;
                  expect_a_d = 1'b0;
                  good_d     = '0;
               end else if (expect_a_q) begin
                  // The pair that completes lock is swallowed, not emitted
                  good_d     = good_inc_c;
                  expect_a_d = 1'b0;
                  if (good_inc_c == GW'(LOCK_PAIRS)) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  hold_b_d   = word_conv_c;
                  expect_a_d = 1'b1;
               end
            end

            ST_LOCKED: begin
               if (!word_ok_c) begin
                  state_d    = ST_HUNT;
                  expect_a_d = 1'b0;
                  good_d     = '0;
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + ECW'(1);
                  end
               end else if (expect_a_q) begin
                  dat_a_d    = word_conv_c;
                  dat_b_d    = hold_b_q;
                  valid_d    = 1'b1;
                  pair_cnt_d = pair_cnt_q + PCW'(1);
                  expect_a_d = 1'b0;
               end else begin
                  hold_b_d   = word_conv_c;
                  expect_a_d = 1'b1;
               end
            end

            default: begin
               state_d    = ST_HUNT;
               expect_a_d = 1'b0;
               good_d     = '0;
            end
         endcase
      end

      locked_d = (state_d == ST_LOCKED);
   end

   // Framing state register
   always_ff @(posedge dac_clk_2x) begin
      if (dac_rst) begin
         state_q    <= ST_HUNT;
         expect_a_q <= 1'b0;
         good_q     <= '0;
         hold_b_q   <= '0;
      end else begin
         state_q    <= state_d;
         expect_a_q <= expect_a_d;
         good_q     <= good_d;
         hold_b_q   <= hold_b_d;
      end
   end

   // Output registers
   always_ff @(posedge dac_clk_2x) begin
      if (dac_rst) begin
         dat_a_q    <= '0;
         dat_b_q    <= '0;
         valid_q    <= 1'b0;
         locked_q   <= 1'b0;
         err_cnt_q  <= '0;
         pair_cnt_q <= '0;
      end else begin
         dat_a_q    <= dat_a_d;
         dat_b_q    <= dat_b_d;
         valid_q    <= valid_d;
         locked_q   <= locked_d;
         err_cnt_q  <= err_cnt_d;
         pair_cnt_q <= pair_cnt_d;
      end
   end

   assign dat_a_o    = dat_a_q;
   assign dat_b_o    = dat_b_q;
   assign valid_o    = valid_q;
   assign locked_o   = locked_q;
   assign err_cnt_o  = err_cnt_q;
   assign pair_cnt_o = pair_cnt_q;

endmodule

// File: tb/tb_dac_bus_rx.sv
// Testbench for dac_bus_rx. Expected pairs are queued when they are driven.
// A monitor pops each queued pair and compares it on every valid_o pulse.
module tb_dac_bus_rx;

   logic        dac_clk_2x = 1'b0;
   logic        dac_rst    = 1'b1;
   logic [13:0] dac_dat_i  = '0;
   logic        dac_sel_i  = 1'b0;
   logic        dac_vld_i  = 1'b0;
   logic [13:0] dat_a_o;
   logic [13:0] dat_b_o;
   logic        valid_o;
   logic        locked_o;
   logic [15:0] err_cnt_o;
   logic [31:0] pair_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;
   int vld_seen = 0;
   logic [31:0] exp_pairs = '0;
   logic [15:0] exp_err = '0;
   logic [27:0] q_exp[$];

   dac_bus_rx #(.LOCK_PAIRS(4)) dut (
      .dac_clk_2x (dac_clk_2x),
      .dac_rst    (dac_rst),
      .dac_dat_i  (dac_dat_i),
      .dac_sel_i  (dac_sel_i),
      .dac_vld_i  (dac_vld_i),
      .dat_a_o    (dat_a_o),
      .dat_b_o    (dat_b_o),
      .valid_o    (valid_o),
      .locked_o   (locked_o),
      .err_cnt_o  (err_cnt_o),
      .pair_cnt_o (pair_cnt_o)
   );

   always #5 dac_clk_2x = ~dac_clk_2x;

   // Decoded value is 8191 minus the raw code, as a 14-bit two's complement word
   function automatic logic [13:0] model(input logic [13:0] raw);
      int v;
      v = 8191 - int'(raw);
      return 14'(v);
   endfunction

   // Scoreboard: every valid_o pulse must match the oldest queued pair
   always @(posedge dac_clk_2x) begin
      #1;
      if (valid_o) begin
         logic [27:0] e;
         vld_seen++;
         n_cmp++;
         if (q_exp.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: valid_o with a=%h b=%h, nothing expected", dat_a_o, dat_b_o);
         end else begin
            e = q_exp.pop_front();
            if ({dat_a_o, dat_b_o} !== e) begin
               n_bad++;
               $display("FAIL sb_pair: got a=%h b=%h, expected a=%h b=%h",
                        dat_a_o, dat_b_o, e[27:14], e[13:0]);
            end
         end
      end
   end

   // Drive one word for one cycle (called at a falling edge)
   task automatic put(input logic sel, input logic [13:0] raw);
      dac_sel_i = sel;
      dac_dat_i = raw;
      dac_vld_i = 1'b1;
      @(negedge dac_clk_2x);
   endtask

   task automatic idle(input int n);
      dac_vld_i = 1'b0;
      repeat (n) @(negedge dac_clk_2x);
   endtask

   task automatic send_pair(input logic [13:0] b_raw, input logic [13:0] a_raw, input bit emit);
      if (emit) begin
         q_exp.push_back({model(a_raw), model(b_raw)});
         exp_pairs = exp_pairs + 32'd1;
      end
      put(1'b1, b_raw);
      put(1'b0, a_raw);
   endtask

   // From HUNT: four clean pairs reach LOCKED without emitting anything
   task automatic relock();
      for (int i = 0; i < 4; i++)
         send_pair(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 1'b0);
      idle(1);
   endtask

   task automatic check_counts(input string tag);
      n_cmp++;
      if (pair_cnt_o !== exp_pairs) begin
         n_bad++;
         $display("FAIL %s_pair_cnt: got %h expected %h", tag, pair_cnt_o, exp_pairs);
      end
      n_cmp++;
      if (err_cnt_o !== exp_err) begin
         n_bad++;
         $display("FAIL %s_err_cnt: got %h expected %h", tag, err_cnt_o, exp_err);
      end
   endtask

   task automatic check_all_zero(input string tag);
      n_cmp++;
      if ({dat_a_o, dat_b_o, valid_o, locked_o, err_cnt_o, pair_cnt_o} !== '0) begin
         n_bad++;
         $display("FAIL %s_zero: a=%h b=%h v=%b l=%b e=%h p=%h expected all 0",
                  tag, dat_a_o, dat_b_o, valid_o, locked_o, err_cnt_o, pair_cnt_o);
      end
   endtask

   task automatic check_locked(input string tag, input logic exp);
      n_cmp++;
      if (locked_o !== exp) begin
         n_bad++;
         $display("FAIL %s_locked: got %b expected %b", tag, locked_o, exp);
      end
   endtask

   task automatic test_reset();
      dac_rst = 1'b1;
      repeat (2) @(negedge dac_clk_2x);
      check_all_zero("reset");
      dac_rst = 1'b0;
   endtask

   task automatic test_lockup();
      for (int i = 0; i < 4; i++)
         send_pair(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 1'b0);
      check_locked("lock_early", 1'b0);
      idle(1);
      check_locked("lock_up", 1'b1);
      n_cmp++;
      if (vld_seen !== 0) begin
         n_bad++;
         $display("FAIL lock_no_emit: got %0d valid pulses expected 0", vld_seen);
      end
      send_pair(14'h0123, 14'h2abc, 1'b1);
      idle(1);
      n_cmp++;
      if (valid_o !== 1'b1) begin
         n_bad++;
         $display("FAIL first_valid: got %b expected 1", valid_o);
      end
      check_counts("lockup");
   endtask

   task automatic test_conversion();
      send_pair(14'h3fff, 14'h0000, 1'b1);
      idle(1);
      n_cmp++;
      if (dat_b_o !== 14'h2000 || dat_a_o !== 14'h1fff) begin
         n_bad++;
         $display("FAIL conv_extreme: got b=%h a=%h expected b=2000 a=1fff", dat_b_o, dat_a_o);
      end
      send_pair(14'h2000, 14'h1fff, 1'b1);
      idle(3);
      n_cmp++;
      if (dat_b_o !== 14'h3fff || dat_a_o !== 14'h0000) begin
         n_bad++;
         $display("FAIL conv_mid: got b=%h a=%h expected b=3fff a=0000 (held)", dat_b_o, dat_a_o);
      end
   endtask

   task automatic test_back_to_back();
      int start;
      start = vld_seen;
      for (int i = 0; i < 8; i++)
         send_pair(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 1'b1);
      idle(2);
      n_cmp++;
      if (vld_seen - start !== 8) begin
         n_bad++;
         $display("FAIL b2b_count: got %0d pulses expected 8", vld_seen - start);
      end
      check_counts("b2b");
   endtask

   task automatic test_gaps();
      int start;
      start = vld_seen;
      q_exp.push_back({model(14'h1555), model(14'h0aaa)});
      exp_pairs = exp_pairs + 32'd1;
      put(1'b1, 14'h0aaa);
      idle(7);
      put(1'b0, 14'h1555);
      n_cmp++;
      if (valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL gap_early: valid_o got %b expected 0 one cycle after A", valid_o);
      end
      idle(1);
      n_cmp++;
      if (valid_o !== 1'b1) begin
         n_bad++;
         $display("FAIL gap_valid: valid_o got %b expected 1 two cycles after A", valid_o);
      end
      idle(2);
      n_cmp++;
      if (vld_seen - start !== 1) begin
         n_bad++;
         $display("FAIL gap_count: got %0d pulses expected 1", vld_seen - start);
      end
   endtask

   task automatic test_framing();
      int start;
      start = vld_seen;
      put(1'b1, 14'h0100);
      put(1'b1, 14'h0200);
      exp_err = exp_err + 16'd1;
      idle(1);
      check_locked("frame_drop", 1'b0);
      check_counts("frame_err");
      n_cmp++;
      if (vld_seen !== start) begin
         n_bad++;
         $display("FAIL frame_no_valid: got %0d pulses expected 0", vld_seen - start);
      end
      relock();
      check_locked("frame_relock", 1'b1);
      send_pair(14'h0777, 14'h3888, 1'b1);
      idle(2);
      check_counts("frame_after");
   endtask

   task automatic test_saturation();
      @(negedge dac_clk_2x);
      force dut.err_cnt_q = 16'hfffe;
      @(negedge dac_clk_2x);
      release dut.err_cnt_q;
      exp_err = 16'hfffe;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) relock();
         put(1'b0, 14'h0011);
         put(1'b0, 14'h0022);
         idle(1);
         exp_err = 16'hffff;
         n_cmp++;
         if (err_cnt_o !== 16'hffff) begin
            n_bad++;
            $display("FAIL err_sat_%0d: got %h expected ffff", i, err_cnt_o);
         end
      end
      relock();
      force dut.pair_cnt_q = 32'hffffffff;
      @(negedge dac_clk_2x);
      release dut.pair_cnt_q;
      exp_pairs = 32'hffffffff;
      send_pair(14'h1234, 14'h0321, 1'b1);
      idle(1);
      n_cmp++;
      if (pair_cnt_o !== 32'h0) begin
         n_bad++;
         $display("FAIL pair_wrap: got %h expected 00000000", pair_cnt_o);
      end
      check_counts("sat");
   endtask

   task automatic test_reset_mid();
      int start;
      put(1'b1, 14'h0fff);
      dac_vld_i = 1'b0;
      dac_rst = 1'b1;
      @(negedge dac_clk_2x);
      dac_rst = 1'b0;
      exp_pairs = '0;
      exp_err = '0;
      check_all_zero("rst_mid");
      start = vld_seen;
      put(1'b0, 14'h0fff);
      idle(3);
      n_cmp++;
      if (vld_seen !== start || valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_lone_a: got %0d pulses expected 0", vld_seen - start);
      end
      check_locked("rst_hunt", 1'b0);
      check_counts("rst_mid");
   endtask

   initial begin
      @(negedge dac_clk_2x);
      test_reset();
      test_lockup();
      test_conversion();
      test_back_to_back();
      test_gaps();
      test_framing();
      test_saturation();
      test_reset_mid();
      idle(2);
      n_cmp++;
      if (q_exp.size() !== 0) begin
         n_bad++;
         $display("FAIL sb_leftover: got %0d pending pairs expected 0", q_exp.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
